// File: rtl/lp_tree_loader.sv
// lp_tree_loader: front-end word loader for the low-power tree serializer.
// Buffers core words in a small FIFO and hands one word to the tree leaves
// every WIDTH/2 cycles. When no data is available it issues IDLE_WORD instead.
// Optional build macro LP_TREE_LOADER_STATS_EN adds a saturating underflow
// counter on output ufl_cnt_o.
module lp_tree_loader #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 4,
  parameter int               PRIME_LVL = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       tree_rdy_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [WIDTH-1:0]           word_o,
  output logic                       load_o,
  output logic                       underflow_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
`ifdef LP_TREE_LOADER_STATS_EN
  ,
  output logic [15:0]                ufl_cnt_o
`endif
);

  localparam int PERIOD = WIDTH / 2;
  localparam int CNT_W  = $clog2(PERIOD);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             load_q, load_d;
  logic             ufl_q, ufl_d;
  logic             push, pop;

  logic [WIDTH-1:0] mem [DEPTH];

  // Accept a word whenever a slot was free at the start of the cycle; a pop in
  // the same cycle cannot raise ready_o until the next cycle.
  assign ready_o = (level_q < LVL_W'(DEPTH));
  assign push    = valid_i && ready_o;

  // Sequencer: period counter, WAIT/PRIME/RUN state and leaf word selection.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    load_d  = 1'b0;
    ufl_d   = 1'b0;
    pop     = 1'b0;
    if (!tree_rdy_i) begin
      // Tree held in reset: park, keep FIFO contents, restart the period.
      state_d = ST_WAIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          cnt_d   = '0;
          state_d = ST_PRIME;
        end
        ST_PRIME, ST_RUN: begin
          if (cnt_q == CNT_W'(PERIOD - 1)) begin
            cnt_d  = '0;
            load_d = 1'b1;
            if (state_q == ST_RUN || level_q >= LVL_W'(PRIME_LVL)) begin
              state_d = ST_RUN;
              if (level_q != '0) begin
                pop    = 1'b1;
                word_d = mem[rd_ptr_q];
              end else begin
                word_d = IDLE_WORD;
                ufl_d  = 1'b1;
              end
            end else begin
              // Still priming: feed idle words without counting underflows.
              word_d = IDLE_WORD;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FIFO bookkeeping: pointers wrap naturally, occupancy tracked separately.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    if (!rst_i) begin
      state_q  <= ST_WAIT;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      word_q   <= IDLE_WORD;
      load_q   <= 1'b0;
      ufl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      word_q   <= word_d;
      load_q   <= load_d;
      ufl_q    <= ufl_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; occupancy gates every read, so
    // stale contents are never observed and the array can map to plain RAM.
    if (push) mem[wr_ptr_q] <= data_i;
  end

  assign word_o      = word_q;
  assign load_o      = load_q;
  assign underflow_o = ufl_q;
  assign level_o     = level_q;

`ifdef LP_TREE_LOADER_STATS_EN
  logic [15:0] ufl_cnt_q, ufl_cnt_d;

  // Saturating underflow counter, cleared while the tree is held in reset.
  always_comb begin
    ufl_cnt_d = ufl_cnt_q;
    if (!tree_rdy_i)                         ufl_cnt_d = '0;
    else if (ufl_d && ufl_cnt_q != 16'hFFFF) ufl_cnt_d = ufl_cnt_q + 1'b1;
  end

  // Underflow counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ufl_cnt_q <= '0;
    else        ufl_cnt_q <= ufl_cnt_d;
  end

  assign ufl_cnt_o = ufl_cnt_q;
`endif

endmodule

// File: tb/tb_lp_tree_loader.sv
// Self-checking bench for lp_tree_loader (WIDTH=16, DEPTH=4, PRIME_LVL=2).
// Table-driven vectors for FIFO fill/back-pressure, hand sequences for the
// load timing, priming, underflow and tree-reset corner cases.
module tb_lp_tree_loader;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        tree_rdy;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic [15:0] word;
  logic        load;
  logic        ufl;
  logic [2:0]  level;
`ifdef LP_TREE_LOADER_STATS_EN
  logic [15:0] ufl_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  lp_tree_loader #(
    .WIDTH(16), .DEPTH(4), .PRIME_LVL(2), .IDLE_WORD(16'h0000)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .tree_rdy_i  (tree_rdy),
    .data_i      (data),
    .valid_i     (valid),
    .ready_o     (ready),
    .word_o      (word),
    .load_o      (load),
    .underflow_o (ufl),
    .level_o     (level)
`ifdef LP_TREE_LOADER_STATS_EN
    ,
    .ufl_cnt_o   (ufl_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        valid;
    logic [15:0] data;
    logic        exp_ready;
    logic [2:0]  exp_level;
    logic        exp_load;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until load_o is seen (bounded) and check how many edges it took.
  task automatic run_to_load(input int exp_edges, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!load && n < 40);
    check(name, n, exp_edges);
  endtask

  vec_t vecs[6];

  initial begin
    // Fill with tree in reset: level climbs to DEPTH, 5th word is refused.
    vecs[0] = '{1'b0, 1'b1, 16'h1111, 1'b1, 3'd1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h2222, 1'b1, 3'd2, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h3333, 1'b1, 3'd3, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'h4444, 1'b0, 3'd4, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 16'h5555, 1'b0, 3'd4, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 16'h5555, 1'b0, 3'd4, 1'b0};

    rst_i = 1'b0; tree_rdy = 1'b0; valid = 1'b0; data = '0;
    repeat (2) step();
    check("rst_ready", ready, 1);
    check("rst_level", level, 0);
    check("rst_word",  word,  16'h0000);
    check("rst_load",  load,  0);
    check("rst_ufl",   ufl,   0);
    rst_i = 1'b1;
    step();

    // Priming with no data: first load 8 cycles after the edge sampling
    // tree_rdy (9 edges counting that edge), idle words, no underflow.
    tree_rdy = 1'b1;
    run_to_load(9, "first_load_latency");
    check("prime1_word", word, 16'h0000);
    check("prime1_ufl",  ufl,  0);
    run_to_load(8, "prime2_latency");
    check("prime2_word", word, 16'h0000);
    check("prime2_ufl",  ufl,  0);

    // Two pushes satisfy PRIME_LVL; then drain and underflow.
    valid = 1'b1; data = 16'hA5A5; step();
    data = 16'h3C3C; step();
    valid = 1'b0;
    check("push2_level", level, 2);
    run_to_load(6, "run1_latency");
    check("run1_word",  word,  16'hA5A5);
    check("run1_ufl",   ufl,   0);
    check("run1_level", level, 1);
    step();
    check("run1_load_pulse", load, 0);
    run_to_load(7, "run2_latency");
    check("run2_word",  word,  16'h3C3C);
    check("run2_level", level, 0);
    run_to_load(8, "run3_latency");
    check("run3_word", word, 16'h0000);
    check("run3_ufl",  ufl,  1);

    // Push in the same cycle as an empty-FIFO load.
    repeat (7) step();
    valid = 1'b1; data = 16'h7E81; step();
    valid = 1'b0;
    check("simul_load",  load,  1);
    check("simul_ufl",   ufl,   1);
    check("simul_word",  word,  16'h0000);
    check("simul_level", level, 1);
    step();
    check("simul_level_mid", level, 1);
    check("simul_ufl_pulse", ufl,   0);
    run_to_load(7, "simul_next_latency");
    check("simul_next_word",  word,  16'h7E81);
    check("simul_next_ufl",   ufl,   0);
    check("simul_next_level", level, 0);
`ifdef LP_TREE_LOADER_STATS_EN
    check("stats_cnt", ufl_cnt, 2);
`endif

    // Drop tree_rdy mid-RUN with three entries queued.
    valid = 1'b1; data = 16'h1001; step();
    data = 16'h2002; step();
    data = 16'h3003; step();
    valid = 1'b0;
    check("drop_level_pre", level, 3);
    repeat (2) step();
    tree_rdy = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 17; i++) begin
        step();
        if (load) seen++;
      end
      check("drop_no_load", seen, 0);
    end
    check("drop_level_hold", level, 3);
`ifdef LP_TREE_LOADER_STATS_EN
    check("stats_clear", ufl_cnt, 0);
`endif
    tree_rdy = 1'b1;
    run_to_load(9, "resume_latency");
    check("resume_word",  word,  16'h1001);
    check("resume_level", level, 2);
    check("resume_ufl",   ufl,   0);

    // Asynchronous reset mid-cycle clears state immediately.
    #2 rst_i = 1'b0;
    #1;
    check("async_rst_level", level, 0);
    check("async_rst_word",  word,  16'h0000);
    check("async_rst_ready", ready, 1);
    tree_rdy = 1'b0;
    step();
    rst_i = 1'b1;

    // Table: fill to full with the tree held in reset.
    for (int i = 0; i < 6; i++) begin
      tree_rdy = vecs[i].rdy;
      valid    = vecs[i].valid;
      data     = vecs[i].data;
      step();
      check($sformatf("vec%0d_ready", i), ready, vecs[i].exp_ready);
      check($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
      check($sformatf("vec%0d_load",  i), load,  vecs[i].exp_load);
    end

    // Held 5th word enters only after the first pop frees a slot.
    tree_rdy = 1'b1; valid = 1'b1; data = 16'h5555;
    run_to_load(9, "full_load_latency");
    check("full_pop_word",  word,  16'h1111);
    check("full_pop_level", level, 3);
    check("full_pop_ready", ready, 1);
    step();
    valid = 1'b0;
    check("held_push_level", level, 4);
    check("held_push_ready", ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lp_tree_loader.md
# lp_tree_loader

Front-end word loader for the low-power tree serializer. It accepts parallel words from the core over a valid/ready handshake and buffers them in a small FIFO. It presents one word to the serializer tree's leaf registers at the fixed rate the tree consumes them, inserting an idle word whenever the FIFO runs dry. It runs on the full-rate clock that also drives the clock divider, and starts only after the divider releases the tree from reset.

## Interface
Parameters:
- WIDTH, 16: serialized word width; even power of two, minimum 4.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- PRIME_LVL, 2: entries required before the first real word is issued; 1..DEPTH.
- IDLE_WORD, 16'h0000: word issued when no data is available; WIDTH bits.

Ports:
- clk_i  in  1  full-rate serializer clock.
- rst_i  in  1  reset, asynchronous, active-low.
- tree_rdy_i  in  1  tree out of reset; driven by the clock divider's rst0_o, synchronous to clk_i.
- data_i  in  WIDTH  parallel word from the core.
- valid_i  in  1  data_i valid.
- ready_o  out  1  FIFO can accept a word.
- word_o  out  WIDTH  word presented to the tree leaves.
- load_o  out  1  one-cycle strobe; the tree captures word_o on this cycle.
- underflow_o  out  1  one-cycle pulse; IDLE_WORD was issued while in RUN.
- level_o  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Push: occurs when valid_i && ready_o.
- ready_o = (level_o < DEPTH). It is combinational from the occupancy register only; it never depends on valid_i.
- Period counter (PERIOD = WIDTH/2, range 0..PERIOD-1):
  - Counts only outside WAIT.
  - load_o asserts in the cycle the counter equals PERIOD-1; the counter then wraps to 0.
- State machine:
  - WAIT:
    - Counter held at 0; load_o = 0; word_o holds its value.
    - Go to PRIME when tree_rdy_i = 1.
  - PRIME:
    - Each load issues IDLE_WORD, with no pop and no underflow_o.
    - Go to RUN when level_o >= PRIME_LVL at a load cycle. That load already pops and issues the head entry.
  - RUN:
    - Each load pops the head entry onto word_o.
    - If the FIFO is empty at that load: issue IDLE_WORD and pulse underflow_o.
    - Remain in RUN after an underflow; there is no re-priming.
  - From any state: tree_rdy_i = 0 forces WAIT on the next cycle. FIFO contents are kept and the counter is cleared.
- Simultaneous push and pop:
  - Both take effect and level_o is unchanged.
  - If the FIFO is empty, the pop underflows; the pushed word is stored and issued at the next load.
- When full, ready_o = 0. A pop in that cycle frees a slot, but ready_o rises only in the next cycle.
- Pointers wrap modulo DEPTH. Occupancy is tracked separately, so full and empty are unambiguous.

## Timing
- Reset values (async assert, sync deassert assumed upstream):
  - state = WAIT, counter = 0, level_o = 0.
  - ready_o = 1, word_o = IDLE_WORD, load_o = 0, underflow_o = 0.
- First load_o: PERIOD cycles after the first clk_i edge that samples tree_rdy_i = 1.
- word_o and load_o are registered and update on the same edge. word_o is then stable for PERIOD cycles, until the next load.
- Latency: a word pushed at edge t is eligible for any load whose register update occurs at edge t+1 or later.
- Throughput: one word per PERIOD cycles. Sustained input above that rate back-pressures through ready_o.
- underflow_o is registered and coincident with the load_o of the idle word.

## Configuration
- LP_TREE_LOADER_STATS_EN defined:
  - Adds output ufl_cnt_o [15:0], reset 0.
  - Increments on each underflow_o and saturates at 16'hFFFF.
  - Cleared when tree_rdy_i = 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then tree_rdy_i = 1 with no data (WIDTH=16) -> first load_o 8 cycles later; word_o = 16'h0000 and underflow_o = 0 for every load while in PRIME.
- Push 16'hA5A5 then 16'h3C3C, PRIME_LVL=2 -> next load issues A5A5, the following load issues 3C3C; level_o = 0 after that; the third load issues 0000 with underflow_o = 1.
- Push 5 words back-to-back with DEPTH=4 and tree_rdy_i = 0 -> ready_o falls after the 4th push and level_o = 4; the 5th word is held by the source until a pop occurs.
- Push 1 word in the same cycle as a RUN-state load with an empty FIFO -> underflow_o pulses; the pushed word appears at the next load; level_o reads 1 in between.
- Drop tree_rdy_i mid-RUN with 3 entries queued -> load_o stops the next cycle; level_o stays 3; on re-assert, loads resume after 8 cycles, and the PRIME_LVL=2 condition is immediately met.
- With the STATS macro defined, force 3 underflows -> ufl_cnt_o = 3; tree_rdy_i low -> ufl_cnt_o = 0.
